// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a word-addressed data memory without byte enables.
// Byte/halfword/word requests arrive over valid/ready. Loads return sign- or
// zero-extended data. Sub-word stores are done as read-modify-write.
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word requests.
// Without it, halfword accesses ignore addr[0] and word accesses ignore addr[1:0].
module lsu_mem_ctrl #(
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StRsp} state_e;

  state_e            state_q, state_d;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;       // word read during RD, merged for sub-word stores
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic              accept;
  logic              misalign;
  logic              req_err;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;
  logic [31:0]       wr_word;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;

  // Classify the incoming request; an erroring request never touches memory.
  always_comb begin
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((req_size == 2'b01) && req_addr[0]) ||
               ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
    req_err = (req_size == 2'b11) || ({2'b00, req_addr[31:2]} >= MEM_WORDS) || misalign;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_err) begin
            state_d = StRsp;
          end else if (!req_we) begin
            state_d = StRd;
          end else if (req_size == 2'b10) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:    state_d = we_q ? StWr : StRsp;
      StWr:    state_d = StRsp;
      StRsp:   if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pick the addressed lane out of the memory word and extend it.
  always_comb begin
    byte_sel  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = '0;
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
      2'b10:   load_data = mem_rdata;
      default: load_data = '0;
    endcase
  end

  // Merge store data into the previously read word (whole word for word stores).
  always_comb begin
    wr_word = word_q;
    case (size_q)
      2'b00: wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (addr_q[1]) begin
          wr_word[31:16] = wdata_q[15:0];
        end else begin
          wr_word[15:0] = wdata_q[15:0];
        end
      end
      2'b10:   wr_word = wdata_q;
      default: wr_word = word_q;
    endcase
  end

  // State and request/response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      word_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q        <= req_we;
        uns_q       <= req_unsigned;
        size_q      <= req_size;
        addr_q      <= req_addr[ADDR_W+1:0];
        wdata_q     <= req_wdata;
        rsp_err_q   <= req_err;
        rsp_rdata_q <= '0;
      end
      if (state_q == StRd) begin
        word_q <= mem_rdata;
        if (!we_q) begin
          rsp_rdata_q <= load_data;
        end
      end
    end
  end

  assign mem_re    = (state_q == StRd);
  assign mem_we    = (state_q == StWr);
  assign mem_addr  = (mem_re | mem_we) ? addr_q[ADDR_W+1:2] : '0;
  assign mem_wdata = mem_we ? wr_word : '0;
  assign rsp_valid = (state_q == StRsp);
  assign rsp_rdata = rsp_valid ? rsp_rdata_q : '0;
  assign rsp_err   = rsp_valid & rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized traffic
// checked against a byte-array reference model of the data memory.
module tb_lsu_mem_ctrl;

  localparam int unsigned MEM_WORDS = 32;
  localparam int unsigned ADDR_W    = 5;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int tests_run;
  int tests_failed;

  // Data memory attached to the controller.
  logic [31:0] mem [0:MEM_WORDS-1];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  // Reference image of the memory, one entry per byte.
  logic [7:0] ref_mem [0:4*MEM_WORDS-1];

  lsu_mem_ctrl #(
    .MEM_WORDS(MEM_WORDS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    logic e;
    e = (size == 2'd3) || ((addr / 4) >= MEM_WORDS);
`ifdef LSU_MISALIGN_TRAP_EN
    if (size == 2'd1 && (addr % 2) != 0) e = 1'b1;
    if (size == 2'd2 && (addr % 4) != 0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic int unsigned model_base(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd1) return addr - (addr % 2);
    if (size == 2'd2) return addr - (addr % 4);
    return addr;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
    int unsigned base;
    int unsigned n;
    logic [31:0] v;
    base = model_base(size, addr);
    n    = 1 << size;
    v    = 0;
    for (int unsigned i = 0; i < n; i++) v = v | (32'(ref_mem[base+i]) << (8 * i));
    if (!uns && size == 2'd0 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
    if (!uns && size == 2'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  function automatic void model_store(input logic [1:0] size, input logic [31:0] addr,
                                      input logic [31:0] wdata);
    int unsigned base;
    int unsigned n;
    base = model_base(size, addr);
    n    = 1 << size;
    for (int unsigned i = 0; i < n; i++) ref_mem[base+i] = 8'(wdata >> (8 * i));
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    return model_load(2'd2, 1'b0, addr - (addr % 4));
  endfunction

  // ---------------- driver ----------------
  // Issues one request, keeps scrambled request inputs valid while busy, and reports
  // what was observed up to and including the response handshake.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int nre, output int nwe, output logic [31:0] wd,
                        output logic [ADDR_W-1:0] wa, output logic bad, output logic rdy);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; rsp_ready = 1'b1;
    rdy = req_ready; nre = 0; nwe = 0; wd = '0; wa = '0; bad = 1'b0; lat = 1;
    @(posedge clk);
    #1;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_re) nre++;
      if (mem_we) begin nwe++; wd = mem_wdata; wa = mem_addr; end
      if ((mem_re && mem_we) || (!mem_we && mem_wdata != 32'd0) || req_ready) bad = 1'b1;
      if (rsp_valid) break;
      lat++;
    end
    rdata = rsp_rdata; err = rsp_err;
    req_valid = 1'b0;
    @(posedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    tests_run++; if ({rsp_valid, rsp_err, mem_re, mem_we} !== 4'b0) begin tests_failed++; $display("FAIL rst_strobes got %b want 0000", {rsp_valid, rsp_err, mem_re, mem_we}); end
    tests_run++; if ({rsp_rdata, mem_wdata, mem_addr} !== '0) begin tests_failed++; $display("FAIL rst_data got %h/%h/%h want 0", rsp_rdata, mem_wdata, mem_addr); end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_idle got ready %b valid %b want 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_word_store_load;
    logic [31:0] rd, wd; logic err, bad, rdy; int lat, nre, nwe; logic [ADDR_W-1:0] wa;
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
    model_store(2'd2, 32'h10, 32'hDEAD_BEEF);
    tests_run++; if (nwe !== 1 || nre !== 0 || wa !== 5'd4 || wd !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL ws_mem got we %0d re %0d addr %0d data %h want 1 0 4 deadbeef", nwe, nre, wa, wd); end
    tests_run++; if (lat !== 2 || err !== 1'b0 || rd !== 32'd0) begin tests_failed++; $display("FAIL ws_rsp got lat %0d err %b rdata %h want 2 0 0", lat, err, rd); end
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
    tests_run++; if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin tests_failed++; $display("FAIL wl_rdata got %h err %b want deadbeef 0", rd, err); end
    tests_run++; if (lat !== 2 || nre !== 1 || nwe !== 0) begin tests_failed++; $display("FAIL wl_timing got lat %0d re %0d we %0d want 2 1 0", lat, nre, nwe); end
  endtask

  task automatic test_byte_rmw;
    logic [31:0] rd, wd; logic err, bad, rdy; int lat, nre, nwe; logic [ADDR_W-1:0] wa;
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFF_FF5A, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
    model_store(2'd0, 32'h11, 32'hFFFF_FF5A);
    tests_run++; if (wd !== 32'hDEAD_5AEF || wa !== 5'd4) begin tests_failed++; $display("FAIL bs_wdata got %h @%0d want dead5aef @4", wd, wa); end
    tests_run++; if (lat !== 3 || nre !== 1 || nwe !== 1 || err !== 1'b0) begin tests_failed++; $display("FAIL bs_timing got lat %0d re %0d we %0d err %b want 3 1 1 0", lat, nre, nwe, err); end
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
    tests_run++; if (rd !== 32'hFFFF_FFDE) begin tests_failed++; $display("FAIL lb_signed got %h want ffffffde", rd); end
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
    tests_run++; if (rd !== 32'h0000_00DE) begin tests_failed++; $display("FAIL lb_unsigned got %h want 000000de", rd); end
  endtask

  task automatic test_half;
    logic [31:0] rd, wd; logic err, bad, rdy; int lat, nre, nwe; logic [ADDR_W-1:0] wa;
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h8001_1234, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
    model_store(2'd2, 32'h10, 32'h8001_1234);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
    tests_run++; if (rd !== 32'hFFFF_8001) begin tests_failed++; $display("FAIL lh_signed got %h want ffff8001", rd); end
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
    tests_run++; if (rd !== 32'h0000_8001) begin tests_failed++; $display("FAIL lh_unsigned got %h want 00008001", rd); end
    do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
    tests_run++; if (rd !== 32'h0000_1234) begin tests_failed++; $display("FAIL lh_low got %h want 00001234", rd); end
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h1111_ABCD, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
    model_store(2'd1, 32'h12, 32'h1111_ABCD);
    tests_run++; if (wd !== 32'hABCD_1234 || lat !== 3) begin tests_failed++; $display("FAIL sh_wdata got %h lat %0d want abcd1234 3", wd, lat); end
  endtask

  task automatic test_errors;
    logic [31:0] rd, wd; logic err, bad, rdy; int lat, nre, nwe; logic [ADDR_W-1:0] wa;
    do_req(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
    tests_run++; if (err !== 1'b1 || rd !== 32'd0 || lat !== 1 || nre !== 0 || nwe !== 0) begin tests_failed++; $display("FAIL err_range got err %b rdata %h lat %0d re %0d we %0d want 1 0 1 0 0", err, rd, lat, nre, nwe); end
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
    tests_run++; if (err !== 1'b1 || rd !== 32'd0 || lat !== 1 || nre !== 0 || nwe !== 0) begin tests_failed++; $display("FAIL err_size got err %b rdata %h lat %0d re %0d we %0d want 1 0 1 0 0", err, rd, lat, nre, nwe); end
    do_req(1'b1, 2'd0, 1'b0, 32'h84, 32'h77, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
    tests_run++; if (err !== 1'b1 || nre !== 0 || nwe !== 0) begin tests_failed++; $display("FAIL err_store got err %b re %0d we %0d want 1 0 0", err, nre, nwe); end
    // Last in-range word.
    do_req(1'b1, 2'd2, 1'b0, 32'h7C, 32'h1357_9BDF, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
    model_store(2'd2, 32'h7C, 32'h1357_9BDF);
    do_req(1'b0, 2'd2, 1'b0, 32'h7C, 32'h0, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
    tests_run++; if (err !== 1'b0 || rd !== 32'h1357_9BDF) begin tests_failed++; $display("FAIL top_word got err %b rdata %h want 0 13579bdf", err, rd); end
  endtask

  task automatic test_misalign;
    logic [31:0] rd, wd, exp; logic err, bad, rdy; int lat, nre, nwe; logic [ADDR_W-1:0] wa;
    exp = model_word(32'h10);
    do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
`ifdef LSU_MISALIGN_TRAP_EN
    tests_run++; if (err !== 1'b1 || rd !== 32'd0 || nre !== 0) begin tests_failed++; $display("FAIL misalign got err %b rdata %h re %0d want 1 0 0", err, rd, nre); end
`else
    tests_run++; if (err !== 1'b0 || rd !== exp) begin tests_failed++; $display("FAIL misalign got err %b rdata %h want 0 %h", err, rd, exp); end
`endif
  endtask

  task automatic test_random;
    logic [31:0] rd, wd, a, d, exp_rd, exp_wd; logic err, bad, rdy, we, uns, exp_err;
    logic [1:0] sz; int lat, nre, nwe, exp_lat; logic [ADDR_W-1:0] wa;
    for (int w = 0; w < int'(MEM_WORDS); w++) begin
      d = $urandom;
      do_req(1'b1, 2'd2, 1'b0, 32'(w * 4), d, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
      model_store(2'd2, 32'(w * 4), d);
      tests_run++; if (err !== 1'b0 || wd !== d || wa !== ADDR_W'(w)) begin tests_failed++; $display("FAIL fill[%0d] got err %b data %h @%0d want 0 %h", w, err, wd, wa, d); end
    end
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom); d = $urandom;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4 * MEM_WORDS - 1));
      exp_err = model_err(sz, a);
      exp_rd  = 32'd0;
      exp_wd  = 32'd0;
      if (!exp_err && !we) exp_rd = model_load(sz, uns, a);
      if (!exp_err && we) begin model_store(sz, a, d); exp_wd = model_word(a); end
      exp_lat = exp_err ? 1 : ((we && sz != 2'd2) ? 3 : 2);
      do_req(we, sz, uns, a, d, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
      tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL rnd%0d ready got %b want 1", n, rdy); end
      tests_run++; if (err !== exp_err || rd !== exp_rd) begin tests_failed++; $display("FAIL rnd%0d rsp (we %b sz %0d a %h) got err %b rdata %h want %b %h", n, we, sz, a, err, rd, exp_err, exp_rd); end
      tests_run++; if (lat !== exp_lat) begin tests_failed++; $display("FAIL rnd%0d latency got %0d want %0d", n, lat, exp_lat); end
      tests_run++; if (nwe !== int'(!exp_err && we) || nre !== int'(!exp_err && !(we && sz == 2'd2))) begin tests_failed++; $display("FAIL rnd%0d strobes got re %0d we %0d", n, nre, nwe); end
      tests_run++; if (bad !== 1'b0) begin tests_failed++; $display("FAIL rnd%0d strobe_rules got violation %b want 0", n, bad); end
      if (!exp_err && we) begin
        tests_run++; if (wd !== exp_wd || wa !== ADDR_W'(a >> 2)) begin tests_failed++; $display("FAIL rnd%0d wdata got %h @%0d want %h @%0d", n, wd, wa, exp_wd, a >> 2); end
      end
    end
  endtask

  task automatic test_rsp_hold;
    logic [31:0] rd, wd, exp; logic err, bad, rdy, seen; int lat, nre, nwe; logic [ADDR_W-1:0] wa;
    exp = model_word(32'h10);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    // A competing store stays on the request port for the whole transaction.
    req_we = 1'b1; req_wdata = 32'h0BAD_0BAD;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin @(negedge clk); seen = rsp_valid; end
    tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL hold_rsp got rsp_valid %b want 1", seen); end
    for (int i = 0; i < 5; i++) begin
      tests_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp || req_ready !== 1'b0 || mem_we !== 1'b0) begin tests_failed++; $display("FAIL hold[%0d] got valid %b rdata %h ready %b we %b want 1 %h 0 0", i, rsp_valid, rsp_rdata, req_ready, mem_we, exp); end
      @(negedge clk);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL hold_release got valid %b ready %b want 0 1", rsp_valid, req_ready); end
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
    tests_run++; if (rd !== exp) begin tests_failed++; $display("FAIL hold_ignored got %h want %h", rd, exp); end
  endtask

  task automatic test_reset_during_wr;
    logic [31:0] rd, wd, exp; logic err, bad, rdy; int lat, nre, nwe; logic [ADDR_W-1:0] wa;
    exp = model_word(32'h20);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = ~exp; rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (mem_re !== 1'b1) begin tests_failed++; $display("FAIL rstwr_rd got mem_re %b want 1", mem_re); end
    @(negedge clk);
    tests_run++; if (mem_we !== 1'b1) begin tests_failed++; $display("FAIL rstwr_wr got mem_we %b want 1", mem_we); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (mem_we !== 1'b0 || mem_wdata !== 32'd0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rstwr_async got we %b wdata %h ready %b valid %b want 0 0 1 0", mem_we, mem_wdata, req_ready, rsp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, err, lat, nre, nwe, wd, wa, bad, rdy);
    tests_run++; if (rd !== exp || lat !== 2 || rdy !== 1'b1) begin tests_failed++; $display("FAIL rstwr_unchanged got %h lat %0d ready %b want %h 2 1", rd, lat, rdy, exp); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_half();
    test_errors();
    test_misalign();
    test_random();
    test_rsp_hold();
    test_reset_during_wr();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller that sits directly upstream of the data memory.
- Takes byte, halfword and word load/store requests from the pipeline over a valid/ready handshake.
- Drives the word-addressed data memory's read/write strobes, address and write data.
- Returns sign- or zero-extended load data. Sub-word stores use read-modify-write, because the memory has no byte enables.

Parameters:
- MEM_WORDS, 32, number of 32-bit words in the data memory.
- ADDR_W, 5, word-address width driven to memory; must satisfy 2^ADDR_W >= MEM_WORDS.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected, no memory side effect.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  memory read data, combinational from mem_addr.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE. All outputs 0 except req_ready = 1. Internal latches cleared.
  - Any in-flight access is abandoned; mem_we drops immediately.
- FSM states: IDLE, RD, WR, RSP.
  - req_ready = 1 only in IDLE.
  - Accept on req_valid & req_ready; latch we, size, unsigned, addr, wdata.
- Error check at accept (err = 1):
  - req_size = 11.
  - Word address req_addr[31:2] >= MEM_WORDS.
  - Misalignment: half with addr[0] = 1, or word with addr[1:0] != 0.
  - On error: IDLE -> RSP with rsp_err = 1, rsp_rdata = 0. No mem_re or mem_we is ever asserted.
- Transitions from IDLE (no error):
  - Load: -> RD.
  - Word store: -> WR.
  - Byte/half store: -> RD -> WR.
- RD (one cycle):
  - mem_re = 1, mem_addr = addr[ADDR_W+1:2].
  - mem_rdata is captured at the closing edge.
  - Load -> RSP; sub-word store -> WR.
- WR (one cycle):
  - mem_we = 1.
  - mem_wdata = captured word with the target lane replaced, or req_wdata for word stores.
  - -> RSP.
- Lane ordering is little-endian:
  - Byte lane k = addr[1:0] occupies bits 8k+7:8k.
  - Half lane addr[1] occupies bits 31:16 when addr[1] = 1, else 15:0.
- Load extension:
  - Selected lane is sign- or zero-extended to 32 bits per req_unsigned.
  - For word loads, req_unsigned is ignored.
- RSP:
  - rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready -> IDLE.
- Strobe rules:
  - mem_re and mem_we are never both 1.
  - Both are 0 in IDLE and RSP.
  - mem_wdata is 0 when mem_we = 0.
- Latency, accept edge to rsp_valid rising (rsp_ready held high):
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Throughput:
  - The next request can be accepted the cycle after the response handshake.
  - Request inputs are ignored outside IDLE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned half/word requests are errors, as described above.
- Undefined:
  - No misalignment errors.
  - Halfword ignores addr[0]; word ignores addr[1:0].
  - Range and size-11 errors still apply.

Test Plan:
- Word store 0xDEADBEEF to 0x10, then word load 0x10 -> one mem_we pulse with mem_addr = 4; load returns 0xDEADBEEF, rsp_err = 0, 2-cycle latency.
- Word at 0x10 = 0xDEADBEEF; byte store 0x5A to 0x11 -> RD then WR, mem_wdata = 0xDEAD5AEF. Signed byte load 0x13 -> 0xFFFFFFDE; unsigned byte load 0x13 -> 0x000000DE.
- Signed half load 0x12 on 0x8001_1234 -> 0xFFFF8001; unsigned -> 0x00008001.
- Word load 0x80 with MEM_WORDS = 32 -> rsp_err = 1, rdata = 0, no mem strobes. Size 11 gives the same result.
- Word load 0x12 -> rsp_err = 1 with LSU_MISALIGN_TRAP_EN; returns the word at 0x10 without it.
- Response hold and reset:
  - Hold rsp_ready = 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready = 0.
  - Assert rst_n = 0 during WR -> mem_we falls asynchronously and the FSM returns to IDLE.
